// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port data-memory arbiter: FSM state encoding,
// default memory depth and the per-port read/error response record.
package mem_arb_pkg;

  localparam int unsigned ARB_DEPTH = 128;
  localparam int unsigned ARB_DW    = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic              rvalid;
    logic              err;
    logic [ARB_DW-1:0] rdata;
  } arb_rsp_t;

  // Next response for one port. Reads and any out-of-range access answer
  // one cycle after grant; in-range writes produce no response. rdata holds
  // its last value between responses.
  function automatic arb_rsp_t rsp_next(input logic              gnt,
                                        input logic              wr,
                                        input logic              in_range,
                                        input logic [ARB_DW-1:0] rd,
                                        input arb_rsp_t          cur);
    arb_rsp_t r;
    r        = cur;
    r.rvalid = 1'b0;
    r.err    = 1'b0;
    if (gnt) begin
      r.err    = !in_range;
      r.rvalid = !wr || !in_range;
      if (r.rvalid) begin
        r.rdata = in_range ? rd : '0;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_arb_rr2.sv
// Two-way round-robin pick. In IDLE a tie goes to the port that was not
// granted last; while a port owns the memory only that port can be granted.
module mem_arb_rr2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  input  arb_state_e state_i,
  output logic [1:0] gnt_o
);

  // Grant vector from request vector, last winner and ownership state.
  always_comb begin
    gnt_o = '0;
    case (state_i)
      ST_OWN0: gnt_o = {1'b0, req_i[0]};
      ST_OWN1: gnt_o = {req_i[1], 1'b0};
      default: begin
        if (&req_i) begin
          gnt_o = last_i ? 2'b01 : 2'b10;
        end else begin
          gnt_o = req_i;
        end
      end
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port data memory between the CPU load/store unit (port 0)
// and the loader/debug port (port 1). Round-robin with an optional lock for
// atomic sequences; read data is registered and returned one cycle after grant.
// Optional statistics counters are built when MEM_ARB_STATS_EN is defined.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned DEPTH = ARB_DEPTH,
  parameter int unsigned DW    = ARB_DW,
  parameter int unsigned AW    = 32
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          r0_req,
  input  logic          r0_wr,
  input  logic          r0_lock,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  output logic          r0_gnt,
  output logic          r0_rvalid,
  output logic [DW-1:0] r0_rdata,
  output logic          r0_err,
  input  logic          r1_req,
  input  logic          r1_wr,
  input  logic          r1_lock,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  output logic          r1_gnt,
  output logic          r1_rvalid,
  output logic [DW-1:0] r1_rdata,
  output logic          r1_err,
  output logic          mwr,
  output logic          moe,
  output logic [AW-1:0] ma,
  output logic [DW-1:0] mwd,
  input  logic [DW-1:0] mrd
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [31:0]   stat_gnt0,
  output logic [31:0]   stat_gnt1,
  output logic [31:0]   stat_stall
`endif
);

  arb_state_e state_q;
  logic       last_q;
  logic [1:0] gnt;
  logic       inr0;
  logic       inr1;
  arb_rsp_t   rsp0_q, rsp0_d;
  arb_rsp_t   rsp1_q, rsp1_d;

  assign inr0 = (r0_addr < AW'(DEPTH));
  assign inr1 = (r1_addr < AW'(DEPTH));

  mem_arb_rr2 u_rr2 (
    .req_i   ({r1_req, r0_req}),
    .last_i  (last_q),
    .state_i (state_q),
    .gnt_o   (gnt)
  );

  assign r0_gnt = gnt[0];
  assign r1_gnt = gnt[1];

  // Memory pin mux: idle pins are all zero; out-of-range grants assert no strobe.
  always_comb begin
    mwr = 1'b0;
    moe = 1'b0;
    ma  = '0;
    mwd = '0;
    if (gnt[0]) begin
      ma  = r0_addr;
      mwr = r0_wr && inr0;
      moe = !r0_wr && inr0;
      mwd = r0_wr ? r0_wdata : '0;
    end else if (gnt[1]) begin
      ma  = r1_addr;
      mwr = r1_wr && inr1;
      moe = !r1_wr && inr1;
      mwd = r1_wr ? r1_wdata : '0;
    end
  end

  // Next-cycle responses for both ports.
  always_comb begin
    rsp0_d = rsp_next(gnt[0], r0_wr, inr0, mrd, rsp0_q);
    rsp1_d = rsp_next(gnt[1], r1_wr, inr1, mrd, rsp1_q);
  end

  // Response registers; reset drops any pending response.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rsp0_q <= '0;
      rsp1_q <= '0;
    end else begin
      rsp0_q <= rsp0_d;
      rsp1_q <= rsp1_d;
    end
  end

  assign r0_rvalid = rsp0_q.rvalid;
  assign r0_err    = rsp0_q.err;
  assign r0_rdata  = rsp0_q.rdata;
  assign r1_rvalid = rsp1_q.rvalid;
  assign r1_err    = rsp1_q.err;
  assign r1_rdata  = rsp1_q.rdata;

  // Ownership FSM and last-winner tracking. An owner leaves on an unlocked
  // access or by dropping its request.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
    end else begin
      if (|gnt) begin
        last_q <= gnt[1];
      end
      case (state_q)
        ST_IDLE: begin
          if (gnt[0] && r0_lock) begin
            state_q <= ST_OWN0;
          end else if (gnt[1] && r1_lock) begin
            state_q <= ST_OWN1;
          end
        end
        ST_OWN0: if (!r0_req || !r0_lock) state_q <= ST_IDLE;
        ST_OWN1: if (!r1_req || !r1_lock) state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef MEM_ARB_STATS_EN
  logic [31:0] gnt0_cnt_q;
  logic [31:0] gnt1_cnt_q;
  logic [31:0] stall_cnt_q;
  logic        stall;

  assign stall = (r0_req && !gnt[0]) || (r1_req && !gnt[1]);

  // Saturating grant and stall counters.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      gnt0_cnt_q  <= '0;
      gnt1_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (gnt[0] && (gnt0_cnt_q != '1))  gnt0_cnt_q  <= gnt0_cnt_q + 32'd1;
      if (gnt[1] && (gnt1_cnt_q != '1))  gnt1_cnt_q  <= gnt1_cnt_q + 32'd1;
      if (stall && (stall_cnt_q != '1))  stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stat_gnt0  = gnt0_cnt_q;
  assign stat_gnt1  = gnt1_cnt_q;
  assign stat_stall = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a behavioural
// 128-word memory attached to the memory pins.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        r0_req, r0_wr, r0_lock, r0_gnt, r0_rvalid, r0_err;
  logic [31:0] r0_addr, r0_wdata, r0_rdata;
  logic        r1_req, r1_wr, r1_lock, r1_gnt, r1_rvalid, r1_err;
  logic [31:0] r1_addr, r1_wdata, r1_rdata;
  logic        mwr, moe;
  logic [31:0] ma, mwd, mrd;
`ifdef MEM_ARB_STATS_EN
  logic [31:0] stat_gnt0, stat_gnt1, stat_stall;
`endif

  logic [31:0] mem [0:127];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mwr) mem[ma[6:0]] <= mwd;
  end
  assign mrd = (ma < 32'd128) ? mem[ma[6:0]] : 32'hBAD0_BAD0;

  mem_port_arbiter dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .r0_req    (r0_req),
    .r0_wr     (r0_wr),
    .r0_lock   (r0_lock),
    .r0_addr   (r0_addr),
    .r0_wdata  (r0_wdata),
    .r0_gnt    (r0_gnt),
    .r0_rvalid (r0_rvalid),
    .r0_rdata  (r0_rdata),
    .r0_err    (r0_err),
    .r1_req    (r1_req),
    .r1_wr     (r1_wr),
    .r1_lock   (r1_lock),
    .r1_addr   (r1_addr),
    .r1_wdata  (r1_wdata),
    .r1_gnt    (r1_gnt),
    .r1_rvalid (r1_rvalid),
    .r1_rdata  (r1_rdata),
    .r1_err    (r1_err),
    .mwr       (mwr),
    .moe       (moe),
    .ma        (ma),
    .mwd       (mwd),
    .mrd       (mrd)
`ifdef MEM_ARB_STATS_EN
    ,
    .stat_gnt0 (stat_gnt0),
    .stat_gnt1 (stat_gnt1),
    .stat_stall(stat_stall)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One clock edge, then settle.
  task automatic step;
    @(posedge clock);
    #1;
  endtask

  // Move to the falling edge to sample combinational outputs.
  task automatic mid;
    #4;
  endtask

  task automatic idle_in;
    r0_req = 0; r0_wr = 0; r0_lock = 0; r0_addr = '0; r0_wdata = '0;
    r1_req = 0; r1_wr = 0; r1_lock = 0; r1_addr = '0; r1_wdata = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    idle_in();
    for (int i = 0; i < 128; i++) mem[i] = 32'h1000_0000 + 32'(i);

    // Reset state
    step(); step();
    chk("rst_r0_rvalid", 32'(r0_rvalid), 32'd0);
    chk("rst_r1_rvalid", 32'(r1_rvalid), 32'd0);
    chk("rst_r0_rdata", r0_rdata, 32'd0);
    chk("rst_r1_err", 32'(r1_err), 32'd0);
    chk("rst_mwr_moe", {30'd0, mwr, moe}, 32'd0);
    chk("rst_ma", ma, 32'd0);
    chk("rst_mwd", mwd, 32'd0);
    reset_n = 1'b1;
    step();

    // Contention from reset: 0,1,0,1
    r0_req = 1; r0_addr = 32'd20;
    r1_req = 1; r1_addr = 32'd21;
    mid();
    chk("cont1_gnt", {30'd0, r1_gnt, r0_gnt}, 32'b01);
    chk("cont1_ma", ma, 32'd20);
    chk("cont1_moe", 32'(moe), 32'd1);
    step();
    chk("cont1_r0_rvalid", 32'(r0_rvalid), 32'd1);
    chk("cont1_r0_rdata", r0_rdata, 32'h1000_0014);
    chk("cont1_r0_err", 32'(r0_err), 32'd0);
    mid();
    chk("cont2_gnt", {30'd0, r1_gnt, r0_gnt}, 32'b10);
    chk("cont2_ma", ma, 32'd21);
    step();
    chk("cont2_r1_rvalid", 32'(r1_rvalid), 32'd1);
    chk("cont2_r1_rdata", r1_rdata, 32'h1000_0015);
    chk("cont2_r0_rvalid", 32'(r0_rvalid), 32'd0);
    mid();
    chk("cont3_gnt", {30'd0, r1_gnt, r0_gnt}, 32'b01);
    chk("cont3_ma", ma, 32'd20);
    step();
    mid();
    chk("cont4_gnt", {30'd0, r1_gnt, r0_gnt}, 32'b10);
    chk("cont4_ma", ma, 32'd21);
    step();
    idle_in();
    chk("cont4_r1_rvalid", 32'(r1_rvalid), 32'd1);
`ifdef MEM_ARB_STATS_EN
    chk("stat_gnt0", stat_gnt0, 32'd2);
    chk("stat_gnt1", stat_gnt1, 32'd2);
    chk("stat_stall", stat_stall, 32'd4);
`endif

    // Single write then read of addr 5
    r0_req = 1; r0_wr = 1; r0_addr = 32'd5; r0_wdata = 32'hDEAD_BEEF;
    mid();
    chk("wr5_gnt", 32'(r0_gnt), 32'd1);
    chk("wr5_mwr_moe", {30'd0, mwr, moe}, 32'b10);
    chk("wr5_ma", ma, 32'd5);
    chk("wr5_mwd", mwd, 32'hDEAD_BEEF);
    step();
    chk("wr5_no_rsp", 32'(r0_rvalid), 32'd0);
    r0_wr = 0;
    mid();
    chk("rd5_gnt", 32'(r0_gnt), 32'd1);
    chk("rd5_mwr_moe", {30'd0, mwr, moe}, 32'b01);
    step();
    idle_in();
    chk("rd5_rvalid", 32'(r0_rvalid), 32'd1);
    chk("rd5_rdata", r0_rdata, 32'hDEAD_BEEF);
    chk("rd5_err", 32'(r0_err), 32'd0);
    mid();
    chk("idle_ma", ma, 32'd0);
    chk("idle_mwr_moe", {30'd0, mwr, moe}, 32'd0);
    step();
    chk("rd5_rvalid_one_cycle", 32'(r0_rvalid), 32'd0);

    // Lock: r1 owns for three writes while r0 waits (last winner was port 0)
    r0_req = 1; r0_addr = 32'd30;
    r1_req = 1; r1_wr = 1; r1_lock = 1; r1_addr = 32'd10; r1_wdata = 32'hAAAA_0010;
    mid();
    chk("lock1_gnt", {30'd0, r1_gnt, r0_gnt}, 32'b10);
    chk("lock1_ma", ma, 32'd10);
    chk("lock1_mwr", 32'(mwr), 32'd1);
    step();
    r1_addr = 32'd11; r1_wdata = 32'hAAAA_0011;
    mid();
    chk("lock2_gnt", {30'd0, r1_gnt, r0_gnt}, 32'b10);
    chk("lock2_ma", ma, 32'd11);
    step();
    r1_addr = 32'd12; r1_wdata = 32'hAAAA_0012; r1_lock = 0;
    mid();
    chk("lock3_gnt", {30'd0, r1_gnt, r0_gnt}, 32'b10);
    step();
    r1_req = 0; r1_wr = 0;
    mid();
    chk("lock_rel_gnt", {30'd0, r1_gnt, r0_gnt}, 32'b01);
    chk("lock_rel_ma", ma, 32'd30);
    chk("lock_rel_moe", 32'(moe), 32'd1);
    step();
    idle_in();
    chk("lock_r0_rvalid", 32'(r0_rvalid), 32'd1);
    chk("lock_r0_rdata", r0_rdata, 32'h1000_001E);
    chk("mem10", mem[10], 32'hAAAA_0010);
    chk("mem11", mem[11], 32'hAAAA_0011);
    chk("mem12", mem[12], 32'hAAAA_0012);

    // Out of range: write 128, read 200
    r0_req = 1; r0_wr = 1; r0_addr = 32'd128; r0_wdata = 32'h1234_5678;
    mid();
    chk("oor_wr_gnt", 32'(r0_gnt), 32'd1);
    chk("oor_wr_mwr_moe", {30'd0, mwr, moe}, 32'd0);
    step();
    chk("oor_wr_rvalid", 32'(r0_rvalid), 32'd1);
    chk("oor_wr_err", 32'(r0_err), 32'd1);
    chk("oor_wr_rdata", r0_rdata, 32'd0);
    r0_wr = 0; r0_addr = 32'd200;
    mid();
    chk("oor_rd_gnt", 32'(r0_gnt), 32'd1);
    chk("oor_rd_mwr_moe", {30'd0, mwr, moe}, 32'd0);
    step();
    idle_in();
    chk("oor_rd_rvalid", 32'(r0_rvalid), 32'd1);
    chk("oor_rd_err", 32'(r0_err), 32'd1);
    chk("oor_rd_rdata", r0_rdata, 32'd0);
    chk("mem0_intact", mem[0], 32'h1000_0000);
    step();
    chk("oor_err_clears", {30'd0, r0_rvalid, r0_err}, 32'd0);

    // Reset while port 0 owns the memory with a read response pending
    r0_req = 1; r0_lock = 1; r0_addr = 32'd5;
    mid();
    chk("rl_gnt", 32'(r0_gnt), 32'd1);
    step();
    chk("rl_pending", 32'(r0_rvalid), 32'd1);
    reset_n = 1'b0;
    idle_in();
    #1;
    chk("rl_rvalid_cleared", 32'(r0_rvalid), 32'd0);
    chk("rl_rdata_cleared", r0_rdata, 32'd0);
    chk("rl_state_idle", 32'(dut.state_q), 32'(ST_IDLE));
    step();
    reset_n = 1'b1;
    step();
    // Port 0 wins alone, so the next tie must go to port 1
    r0_req = 1; r0_addr = 32'd6;
    mid();
    chk("rl_r0_alone", {30'd0, r1_gnt, r0_gnt}, 32'b01);
    step();
    r0_addr = 32'd7;
    r1_req = 1; r1_addr = 32'd8;
    mid();
    chk("rl_tie_r1", {30'd0, r1_gnt, r0_gnt}, 32'b10);
    chk("rl_tie_ma", ma, 32'd8);
    step();
    chk("rl_r0_rdata", r0_rdata, 32'h1000_0006);
    mid();
    chk("rl_tie_next_r0", {30'd0, r1_gnt, r0_gnt}, 32'b01);
    step();
    chk("rl_r1_rdata", r1_rdata, 32'h1000_0008);
    idle_in();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
